// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit with req/ack memory handshake
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] ld_data,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Last BUSY cycle index before giving up on mem_ack
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  off_q;
  logic [31:0] ld_data_q;
  logic        bus_err_q;

  logic        illegal;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] lane_shifted;
  logic [31:0] ld_ext;

  logic        accept;
  logic        ack_take;
  logic        time_out;

  // Alignment check on the incoming request
  always_comb begin
    illegal = 1'b0;
    case (req_size)
      SIZE_BYTE: illegal = 1'b0;
      SIZE_HALF: illegal = req_addr[0];
      SIZE_WORD: illegal = (req_addr[1:0] != 2'b00);
      default:   illegal = 1'b1;
    endcase
  end

  // Big-endian byte enables and lane-replicated store data
  always_comb begin
    be_calc    = 4'b0000;
    wdata_calc = req_wdata;
    case (req_size)
      SIZE_BYTE: begin
        be_calc    = 4'b1000 >> req_addr[1:0];
        wdata_calc = {4{req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        be_calc    = req_addr[1] ? 4'b0011 : 4'b1100;
        wdata_calc = {2{req_wdata[15:0]}};
      end
      SIZE_WORD: begin
        be_calc    = 4'b1111;
        wdata_calc = req_wdata;
      end
      default: begin
        be_calc    = 4'b0000;
        wdata_calc = req_wdata;
      end
    endcase
  end

  // Lane extraction from the read word; offset 0 lives in bits [31:24]
  always_comb begin
    lane_shifted = mem_rdata << {off_q, 3'b000};
    ld_ext       = mem_rdata;
    case (size_q)
      SIZE_BYTE: begin
        ld_ext = {{24{signed_q & lane_shifted[31]}}, lane_shifted[31:24]};
      end
      SIZE_HALF: begin
        if (off_q[1]) begin
          ld_ext = {{16{signed_q & mem_rdata[15]}}, mem_rdata[15:0]};
        end else begin
          ld_ext = {{16{signed_q & mem_rdata[31]}}, mem_rdata[31:16]};
        end
      end
      default: ld_ext = mem_rdata;
    endcase
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    misalign = 1'b0;
    mem_req  = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    ack_take = 1'b0;
    time_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (illegal) begin
            misalign = 1'b1;
          end else begin
            stall   = 1'b1;
            accept  = 1'b1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ack) begin
          ack_take = 1'b1;
          state_d  = RESP;
        end else if (cnt_q >= CNT_LAST) begin
          time_out = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        // req_valid here is the instruction just serviced, so it is ignored
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured request and load result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'd0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      off_q       <= 2'b00;
      ld_data_q   <= 32'd0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q       <= 8'd0;
        mem_we_q    <= req_we;
        mem_addr_q  <= {req_addr[31:2], 2'b00};
        mem_be_q    <= be_calc;
        mem_wdata_q <= wdata_calc;
        size_q      <= req_size;
        signed_q    <= req_signed;
        off_q       <= req_addr[1:0];
        bus_err_q   <= 1'b0;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (ack_take) begin
        ld_data_q <= mem_we_q ? 32'd0 : ld_ext;
      end
      if (time_out) begin
        ld_data_q <= 32'd0;
        bus_err_q <= 1'b1;
      end
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign ld_data   = ld_data_q;
  assign bus_err   = done & bus_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic [31:0] ld_data;
  logic        misalign;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  mem_stage_lsu #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .ld_data(ld_data), .misalign(misalign),
    .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs may then be changed and outputs observed
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a legal access, wait n_wait BUSY cycles without ack, ack with rdata
  task automatic access(input string tag, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input int n_wait, input logic [31:0] rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_ld);
    int stall_cycles;
    stall_cycles = 0;
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; mem_ack = 1'b0; mem_rdata = 32'h0;
    #1;
    check({tag, " accept stall"}, 32'(stall), 32'd1);
    check({tag, " accept no req"}, 32'(mem_req), 32'd0);
    if (stall) stall_cycles++;
    tick();
    for (int i = 0; i < n_wait; i++) begin
      if (stall) stall_cycles++;
      tick();
    end
    mem_ack = 1'b1; mem_rdata = rdata;
    #1;
    check({tag, " mem_req"}, 32'(mem_req), 32'd1);
    check({tag, " mem_we"}, 32'(mem_we), 32'(we));
    check({tag, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
    check({tag, " mem_be"}, 32'(mem_be), 32'(exp_be));
    if (we) check({tag, " mem_wdata"}, mem_wdata, exp_wdata);
    if (stall) stall_cycles++;
    tick();
    mem_ack = 1'b0;
    #1;
    check({tag, " stall cycles"}, 32'(stall_cycles), 32'(n_wait + 2));
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " resp stall"}, 32'(stall), 32'd0);
    check({tag, " bus_err"}, 32'(bus_err), 32'd0);
    check({tag, " ld_data"}, ld_data, exp_ld);
    tick();
    req_valid = 1'b0;
    #1;
    check({tag, " idle no done"}, 32'(done), 32'd0);
    check({tag, " idle no req"}, 32'(mem_req), 32'd0);
    check({tag, " ld_data held"}, ld_data, exp_ld);
  endtask

  task automatic misaligned(input string tag, input logic [1:0] size, input logic [31:0] addr);
    req_valid = 1'b1; req_we = 1'b0; req_size = size; req_addr = addr;
    #1;
    check({tag, " misalign"}, 32'(misalign), 32'd1);
    check({tag, " stall"}, 32'(stall), 32'd0);
    tick();
    req_valid = 1'b0;
    #1;
    check({tag, " no mem_req"}, 32'(mem_req), 32'd0);
    check({tag, " pulse over"}, 32'(misalign), 32'd0);
  endtask

  initial begin
    int cnt;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst stall", 32'(stall), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst ld_data", ld_data, 32'h0);
    check("rst mem_be", 32'(mem_be), 32'h0);
    check("rst bus_err", 32'(bus_err), 32'd0);

    access("word ld", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF);
    access("sbyte ld", 1'b0, 2'b00, 1'b1, 32'h43, 32'h0, 0, 32'h000000F0, 4'b0001, 32'h0, 32'hFFFFFFF0);
    access("ubyte ld", 1'b0, 2'b00, 1'b0, 32'h43, 32'h0, 0, 32'h000000F0, 4'b0001, 32'h0, 32'h000000F0);
    access("shalf ld0", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 0, 32'h9ABC1234, 4'b1100, 32'h0, 32'hFFFF9ABC);
    access("byte0 ld", 1'b0, 2'b00, 1'b1, 32'h80, 32'h0, 0, 32'h7F00FF00, 4'b1000, 32'h0, 32'h0000007F);
    access("half st", 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD, 0, 32'hFFFFFFFF, 4'b0011, 32'hABCDABCD, 32'h0);
    access("byte st", 1'b1, 2'b00, 1'b0, 32'h41, 32'h1234565A, 2, 32'h0, 4'b0100, 32'h5A5A5A5A, 32'h0);

    misaligned("mis word", 2'b10, 32'h41);
    misaligned("mis half", 2'b01, 32'h11);
    misaligned("mis rsvd", 2'b11, 32'h40);

    access("pre tmo", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 32'h13572468, 4'b1111, 32'h0, 32'h13572468);

    // timeout: mem_ack never arrives
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h200; mem_ack = 1'b0;
    tick();
    cnt = 0;
    while (mem_req && cnt < 40) begin
      cnt++;
      tick();
    end
    check("tmo req cycles", 32'(cnt), 32'd15);
    check("tmo done", 32'(done), 32'd1);
    check("tmo bus_err", 32'(bus_err), 32'd1);
    check("tmo ld_data", ld_data, 32'h0);
    tick();
    req_valid = 1'b0;
    #1;
    check("tmo bus_err pulse", 32'(bus_err), 32'd0);

    // reset while BUSY, then a late ack
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h300;
    tick();
    check("rst mid busy req", 32'(mem_req), 32'd1);
    reset = 1'b1; req_valid = 1'b0;
    tick();
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    #1;
    check("rst mid mem_req", 32'(mem_req), 32'd0);
    check("rst mid stall", 32'(stall), 32'd0);
    check("rst mid done", 32'(done), 32'd0);
    tick();
    mem_ack = 1'b0;
    #1;
    check("late ack done", 32'(done), 32'd0);
    check("late ack req", 32'(mem_req), 32'd0);
    access("post rst", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0, 32'h00008001, 4'b0011, 32'h0, 32'hFFFF8001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
